zero_stuff_upsampler: RTL and testbench

//  Front end of the interpolation filter. Accepts low-rate samples over a valid/ready

---
 rtl/zero_stuff_upsampler.sv | 124 ++++++++++++
 tb/tb_zero_stuff_upsampler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/zero_stuff_upsampler.sv
// Zero-stuffing interpolator front end: buffers low-rate samples in a small FIFO and
// emits each sample followed by UP_FACTOR-1 zeros, one output per clk.
module zero_stuff_upsampler #(
    parameter int DATA_WIDTH = 5,
    parameter int UP_FACTOR  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [DATA_WIDTH-1:0]   in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [DATA_WIDTH-1:0]   out,
    output logic                           out_valid,
    output logic [$clog2(UP_FACTOR)-1:0]   phase,
    output logic                           underflow,
    input  logic                           clr_err
);

    localparam int PH_W = $clog2(UP_FACTOR);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                        state;
    logic signed [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]                 wr_ptr;
    logic [AW-1:0]                 rd_ptr;
    logic [CW-1:0]                 count;
    logic [CW-1:0]                 count_next;
    logic                          push;
    logic                          pop;
    logic                          empty;
    logic                          last_phase;

    assign empty      = (count == '0);
    assign last_phase = (phase == PH_W'(UP_FACTOR - 1));
    assign push       = in_valid && in_ready;
    // A frame boundary (or leaving IDLE) is the only point where the FIFO head is consumed
    assign pop        = !empty && ((state == IDLE) || last_phase);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // FIFO control; in_ready is registered so it tracks !full of the registered count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count    <= count_next;
            in_ready <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    // Output framing FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            phase     <= '0;
            underflow <= 1'b0;
        end else begin
            if (clr_err)
                underflow <= 1'b0;
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (!empty) begin
                        out       <= mem[rd_ptr];
                        out_valid <= 1'b1;
                        state     <= RUN;
                    end else begin
                        out       <= '0;
                        out_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (last_phase) begin
                        phase <= '0;
                        if (!empty) begin
                            out <= mem[rd_ptr];
                        end else begin
                            // Starved at a frame boundary; set overrides a same-cycle clear
                            out       <= '0;
                            out_valid <= 1'b0;
                            underflow <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                        out   <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out       <= '0;
                    out_valid <= 1'b0;
                    phase     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zero_stuff_upsampler.sv
// Self-checking bench for zero_stuff_upsampler (L=4, depth 4, 5-bit samples) with a
// scoreboard queue filled on accepted transfers and drained at phase-0 outputs.
module tb_zero_stuff_upsampler;

    localparam int DW = 5;
    localparam int L  = 4;
    localparam int D  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] out;
    logic                 out_valid;
    logic [1:0]           phase;
    logic                 underflow;
    logic                 clr_err;

    logic signed [DW-1:0] sbq [$];
    logic signed [DW-1:0] exp_s;
    logic                 last_fire;
    int                   passed = 0;
    int                   total  = 0;

    always #5 clk = ~clk;

    zero_stuff_upsampler #(.DATA_WIDTH(DW), .UP_FACTOR(L), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_valid(out_valid), .phase(phase), .underflow(underflow), .clr_err(clr_err)
    );

    // Advance one clock; an accepted transfer is recorded as an expected output
    task automatic tick;
        last_fire = in_valid && in_ready;
        @(posedge clk);
        if (last_fire) sbq.push_back(in_data);
        #1;
    endtask

    task automatic clear_err;
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", in_ready); else passed++;
        total++; if (out !== 5'sd0) $display("FAIL reset_out got=%0d want=0", out); else passed++;
        total++; if (underflow !== 1'b0) $display("FAIL reset_underflow got=%b want=0", underflow); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else passed++;
        total++; if (phase !== 2'd0) $display("FAIL reset_phase got=%0d want=0", phase); else passed++;
        rst = 1'b0;
        tick;
        total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got=%b want=1", in_ready); else passed++;
        total++; if (out !== 5'sd0) $display("FAIL release_out got=%0d want=0", out); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL release_out_valid got=%b want=0", out_valid); else passed++;
    endtask

    task automatic test_single;
        sbq.delete();
        in_valid = 1'b1; in_data = 5'sd7;
        tick;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL single_latency out_valid got=%b want=0", out_valid); else passed++;
        tick;
        total++;
        if (sbq.size() == 0) $display("FAIL single_sample got=%0d want=<queue empty>", out);
        else begin
            exp_s = sbq.pop_front();
            if (out !== exp_s) $display("FAIL single_sample got=%0d want=%0d", out, exp_s); else passed++;
        end
        total++; if (phase !== 2'd0) $display("FAIL single_phase0 got=%0d want=0", phase); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got=%b want=1", out_valid); else passed++;
        for (int i = 1; i < L; i++) begin
            tick;
            total++; if (phase !== 2'(i)) $display("FAIL single_phase got=%0d want=%0d", phase, i); else passed++;
            total++; if (out !== 5'sd0) $display("FAIL single_zero got=%0d want=0", out); else passed++;
        end
        tick;
        total++; if (underflow !== 1'b1) $display("FAIL single_underflow got=%b want=1", underflow); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL single_idle_valid got=%b want=0", out_valid); else passed++;
        total++; if (out !== 5'sd0) $display("FAIL single_idle_out got=%0d want=0", out); else passed++;
    endtask

    task automatic test_clr_err;
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        total++; if (underflow !== 1'b0) $display("FAIL clr_err_clear got=%b want=0", underflow); else passed++;
        in_valid = 1'b1; in_data = -5'sd3;
        tick;
        in_valid = 1'b0;
        tick;
        total++;
        if (sbq.size() == 0) $display("FAIL clr_sample got=%0d want=<queue empty>", out);
        else begin
            exp_s = sbq.pop_front();
            if (out !== exp_s) $display("FAIL clr_sample got=%0d want=%0d", out, exp_s); else passed++;
        end
        repeat (L - 1) tick;
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        total++; if (underflow !== 1'b1) $display("FAIL set_beats_clr got=%b want=1", underflow); else passed++;
        tick;
        total++; if (underflow !== 1'b1) $display("FAIL underflow_sticky got=%b want=1", underflow); else passed++;
        clear_err;
        total++; if (underflow !== 1'b0) $display("FAIL clr_err_again got=%b want=0", underflow); else passed++;
    endtask

    task automatic test_continuous;
        sbq.delete();
        for (int n = 0; n < 13; n++) begin
            in_valid = ((n % L) == 0) && (n < 12);
            in_data  = 5'(n / L + 1);
            tick;
            if (n >= 1) begin
                total++; if (out_valid !== 1'b1) $display("FAIL cont_valid n=%0d got=%b want=1", n, out_valid); else passed++;
                total++; if (underflow !== 1'b0) $display("FAIL cont_underflow n=%0d got=%b want=0", n, underflow); else passed++;
                total++; if (phase !== 2'((n - 1) % L)) $display("FAIL cont_phase n=%0d got=%0d want=%0d", n, phase, (n - 1) % L); else passed++;
                total++;
                if (((n - 1) % L) == 0) begin
                    if (sbq.size() == 0) $display("FAIL cont_sample n=%0d got=%0d want=<queue empty>", n, out);
                    else begin
                        exp_s = sbq.pop_front();
                        if (out !== exp_s) $display("FAIL cont_sample n=%0d got=%0d want=%0d", n, out, exp_s); else passed++;
                    end
                end else begin
                    if (out !== 5'sd0) $display("FAIL cont_zero n=%0d got=%0d want=0", n, out); else passed++;
                end
            end
        end
        in_valid = 1'b0;
        tick;
        total++; if (underflow !== 1'b1) $display("FAIL cont_end_underflow got=%b want=1", underflow); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL cont_end_valid got=%b want=0", out_valid); else passed++;
        clear_err;
    endtask

    task automatic test_back_to_back;
        int  sent;
        int  got;
        bit  done;
        bit  saw_full;
        sent = 0; got = 0; done = 1'b0; saw_full = 1'b0;
        sbq.delete();
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            in_valid = (sent < 8);
            in_data  = 5'(sent + 1);
            tick;
            if (last_fire) sent++;
            if (out_valid && phase == 2'd0) begin
                got++;
                total++;
                if (sbq.size() == 0) $display("FAIL burst_extra got=%0d want=<queue empty>", out);
                else begin
                    exp_s = sbq.pop_front();
                    if (out !== exp_s) $display("FAIL burst_order got=%0d want=%0d", out, exp_s); else passed++;
                end
            end
            total++;
            if (in_ready !== (sbq.size() != D))
                $display("FAIL burst_in_ready got=%b want=%b count=%0d", in_ready, sbq.size() != D, sbq.size());
            else passed++;
            if (!in_ready) saw_full = 1'b1;
            if (sent == 8 && !out_valid && got > 0) done = 1'b1;
        end
        in_valid = 1'b0;
        total++; if (done !== 1'b1) $display("FAIL burst_timeout got=%0d outputs want=8", got); else passed++;
        total++; if (got !== 8) $display("FAIL burst_count got=%0d want=8", got); else passed++;
        total++; if (saw_full !== 1'b1) $display("FAIL burst_backpressure got=%b want=1", saw_full); else passed++;
        total++; if (sbq.size() !== 0) $display("FAIL burst_leftover got=%0d want=0", sbq.size()); else passed++;
        clear_err;
    endtask

    task automatic test_reset_mid;
        sbq.delete();
        in_valid = 1'b1; in_data = -5'sd5;
        tick;
        in_data = 5'sd11;
        tick;
        total++;
        if (sbq.size() == 0) $display("FAIL mid_first got=%0d want=<queue empty>", out);
        else begin
            exp_s = sbq.pop_front();
            if (out !== exp_s) $display("FAIL mid_first got=%0d want=%0d", out, exp_s); else passed++;
        end
        in_data = -5'sd16;
        tick;
        in_valid = 1'b0;
        tick;
        total++; if (phase !== 2'd2) $display("FAIL mid_phase got=%0d want=2", phase); else passed++;
        total++; if (sbq.size() !== 2) $display("FAIL mid_buffered got=%0d want=2", sbq.size()); else passed++;
        rst = 1'b1;
        #1;
        total++; if (out !== 5'sd0) $display("FAIL mid_rst_out got=%0d want=0", out); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b want=0", out_valid); else passed++;
        total++; if (phase !== 2'd0) $display("FAIL mid_rst_phase got=%0d want=0", phase); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL mid_rst_ready got=%b want=0", in_ready); else passed++;
        sbq.delete();
        tick;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            total++; if (out !== 5'sd0) $display("FAIL mid_discard_out i=%0d got=%0d want=0", i, out); else passed++;
            total++; if (out_valid !== 1'b0) $display("FAIL mid_discard_valid i=%0d got=%b want=0", i, out_valid); else passed++;
        end
        total++; if (underflow !== 1'b0) $display("FAIL mid_underflow got=%b want=0", underflow); else passed++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_clr_err;
        test_continuous;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
